// File: rtl/shadow_unload.sv
// Drains CHAINS serial shadow chains one at a time into WORD_W-bit words queued in a FWFT FIFO.
// Optional watchdog enabled by defining SHADOW_UNLOAD_TIMEOUT_EN.
module shadow_unload #(
    parameter int CHAINS     = 4,
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [CHAINS-1:0] dump_en,
    input  logic [CHAINS-1:0] chains_in,
    input  logic [CHAINS-1:0] chains_in_vld,
    input  logic [CHAINS-1:0] chains_in_done,
    output logic [WORD_W-1:0] word_out,
    output logic [4:0]        word_chain,
    output logic              word_last,
    output logic              word_vld,
    input  logic              word_rdy,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(WORD_W);

    if (CHAINS < 1 || CHAINS > 32 || WORD_W < 8 || WORD_W > 64 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
        $error("shadow_unload: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DUMP  = 2'd1,
        FLUSH = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t              state_r, state_n;
    logic [4:0]          k_r, k_n;
    logic [BW-1:0]       bitcnt_r, bitcnt_n;
    logic [WORD_W-1:0]   word_r, word_n, word_set_s;
    logic [CHAINS-1:0]   dump_en_r, dump_en_n;
    logic                busy_r, done_r;

    logic                sel_bit_s, sel_vld_s, sel_done_s;
    logic                en_s, take_s, fin_s, tmo_hit_s;
    logic                push_s, push_last_s, pop_s;
    logic [WORD_W-1:0]   push_word_s;

    logic [WORD_W-1:0]   mem_word [FIFO_DEPTH];
    logic [4:0]          mem_chain[FIFO_DEPTH];
    logic                mem_last [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]       count_r, count_n;
    logic                vld_r;

    // Pick the serial inputs of the chain currently being drained.
    always_comb begin
        sel_bit_s  = 1'b0;
        sel_vld_s  = 1'b0;
        sel_done_s = 1'b0;
        for (int i = 0; i < CHAINS; i++) begin
            sel_bit_s  = (k_r == 5'(i)) ? chains_in[i]      : sel_bit_s;
            sel_vld_s  = (k_r == 5'(i)) ? chains_in_vld[i]  : sel_vld_s;
            sel_done_s = (k_r == 5'(i)) ? chains_in_done[i] : sel_done_s;
        end
    end

    // dump_en_r only ever carries the bit of chain k while in DUMP with room in the FIFO.
    assign en_s   = |dump_en_r;
    assign take_s = en_s & sel_vld_s;
    assign fin_s  = en_s & sel_done_s;
    assign pop_s  = vld_r & word_rdy;

    // Shift word with the incoming bit merged at position bitcnt.
    always_comb begin
        word_set_s           = word_r;
        word_set_s[bitcnt_r] = sel_bit_s;
    end

`ifdef SHADOW_UNLOAD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_r;
    logic          idle_s;
    logic          err_r;

    assign idle_s    = en_s & ~sel_vld_s & ~sel_done_s;
    assign tmo_hit_s = idle_s && (tmo_r == TW'(TIMEOUT - 1));
    assign err       = err_r;

    // Watchdog: consecutive enabled DUMP cycles without any chain activity; backpressure holds it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_r <= '0;
            err_r <= 1'b0;
        end else begin
            err_r <= err_r | tmo_hit_s;
            if (state_r != DUMP || tmo_hit_s) begin
                tmo_r <= '0;
            end else if (idle_s) begin
                tmo_r <= tmo_r + TW'(1);
            end else if (en_s) begin
                tmo_r <= '0;
            end else begin
                tmo_r <= tmo_r;
            end
        end
    end
`else
    assign tmo_hit_s = 1'b0;
    assign err       = 1'b0;
`endif

    // Next-state, deserializer and push control.
    always_comb begin
        state_n     = state_r;
        k_n         = k_r;
        bitcnt_n    = bitcnt_r;
        word_n      = word_r;
        push_s      = 1'b0;
        push_last_s = 1'b0;
        push_word_s = word_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_n  = DUMP;
                    k_n      = 5'd0;
                    bitcnt_n = '0;
                    word_n   = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            DUMP: begin
                if (take_s) begin
                    if (bitcnt_r == BW'(WORD_W - 1)) begin
                        push_s      = 1'b1;
                        push_word_s = word_set_s;
                        word_n      = '0;
                        bitcnt_n    = '0;
                    end else begin
                        word_n   = word_set_s;
                        bitcnt_n = bitcnt_r + BW'(1);
                    end
                end else begin
                    word_n = word_r;
                end
                if (fin_s || tmo_hit_s) begin
                    state_n = FLUSH;
                end else begin
                    state_n = DUMP;
                end
            end
            FLUSH: begin
                // Unwritten bits are already zero, so an empty word flushes as all zeros.
                push_s      = 1'b1;
                push_last_s = 1'b1;
                push_word_s = word_r;
                word_n      = '0;
                bitcnt_n    = '0;
                if (k_r == 5'(CHAINS - 1)) begin
                    state_n = FIN;
                end else begin
                    k_n     = k_r + 5'd1;
                    state_n = DUMP;
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign count_n = count_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};

    // Enable the next cycle's chain only if two words can still land (full word plus flush word).
    always_comb begin
        dump_en_n = '0;
        if (state_n == DUMP && count_n <= CW'(FIFO_DEPTH - 2)) begin
            for (int i = 0; i < CHAINS; i++) begin
                dump_en_n[i] = (k_n == 5'(i));
            end
        end else begin
            dump_en_n = '0;
        end
    end

    // Control state and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            k_r       <= 5'd0;
            bitcnt_r  <= '0;
            word_r    <= '0;
            dump_en_r <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_n;
            k_r       <= k_n;
            bitcnt_r  <= bitcnt_n;
            word_r    <= word_n;
            dump_en_r <= dump_en_n;
            busy_r    <= (state_n != IDLE);
            done_r    <= (state_n == FIN);
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            vld_r    <= 1'b0;
        end else begin
            wr_ptr_r <= push_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
            rd_ptr_r <= pop_s  ? rd_ptr_r + AW'(1) : rd_ptr_r;
            count_r  <= count_n;
            vld_r    <= (count_n != '0);
        end
    end

    // FIFO storage; contents are masked at the output while empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_word[wr_ptr_r]  <= push_word_s;
            mem_chain[wr_ptr_r] <= k_r;
            mem_last[wr_ptr_r]  <= push_last_s;
        end
    end

    assign dump_en    = dump_en_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign word_vld   = vld_r;
    assign word_out   = vld_r ? mem_word[rd_ptr_r]  : '0;
    assign word_chain = vld_r ? mem_chain[rd_ptr_r] : 5'd0;
    assign word_last  = vld_r ? mem_last[rd_ptr_r]  : 1'b0;

endmodule

// File: tb/tb_shadow_unload.sv
// Scoreboard bench for shadow_unload: directed chain traffic, expected words queued at issue time.
module tb_shadow_unload;

    localparam int CHAINS = 2;
    localparam int WORD_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CHAINS-1:0] dump_en;
    logic [CHAINS-1:0] chains_in;
    logic [CHAINS-1:0] chains_in_vld;
    logic [CHAINS-1:0] chains_in_done;
    logic [WORD_W-1:0] word_out;
    logic [4:0]        word_chain;
    logic              word_last;
    logic              word_vld;
    logic              word_rdy;
    logic              busy;
    logic              done;
    logic              err;

    shadow_unload #(.CHAINS(CHAINS), .WORD_W(WORD_W), .FIFO_DEPTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .dump_en(dump_en),
        .chains_in(chains_in), .chains_in_vld(chains_in_vld), .chains_in_done(chains_in_done),
        .word_out(word_out), .word_chain(word_chain), .word_last(word_last),
        .word_vld(word_vld), .word_rdy(word_rdy), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]        ch;
        logic              last;
        logic [WORD_W-1:0] w;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;
    int   done_seen = 0;
    int   bits_taken = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_word(input int ch, input logic last, input logic [WORD_W-1:0] w);
        exp_t e;
        e.ch   = 5'(ch);
        e.last = last;
        e.w    = w;
        sb_q.push_back(e);
    endtask

    // Monitor: compare every word handed over on the output handshake.
    always @(negedge clk) begin
        if (rst && word_vld && word_rdy) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got ch=%0d last=%0b word=0x%0h, required no word",
                         word_chain, word_last, word_out);
            end else begin
                mon_e = sb_q.pop_front();
                chk("word", {18'd0, word_chain, word_last, word_out}, {18'd0, mon_e});
            end
        end
        if (done) done_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Hold one beat on chain c until the DUT has it enabled at a clock edge.
    task automatic send(input int c, input logic b, input logic is_vld, input logic is_done);
        int   cyc;
        logic taken;
        chains_in[c]      = b;
        chains_in_vld[c]  = is_vld;
        chains_in_done[c] = is_done;
        taken = 1'b0;
        cyc   = 0;
        while (!taken && cyc < 200) begin
            @(negedge clk);
            taken = dump_en[c];
            tick();
            cyc++;
        end
        chains_in[c]      = 1'b0;
        chains_in_vld[c]  = 1'b0;
        chains_in_done[c] = 1'b0;
        chk("beat_accepted", {31'd0, taken}, 32'd1);
        if (taken && is_vld) bits_taken++;
    endtask

    task automatic send_bits(input int c, input logic [WORD_W-1:0] val, input int n, input logic done_last);
        logic [WORD_W-1:0] v;
        v = val;
        for (int i = 0; i < n; i++) begin
            send(c, v[i], 1'b1, done_last && (i == n - 1));
        end
    endtask

    task automatic wait_done();
        int   cyc;
        logic seen;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 30) begin
            @(negedge clk);
            seen = done;
            cyc++;
        end
        chk("done_pulse", {31'd0, seen}, 32'd1);
        @(negedge clk);
        chk("done_single_cycle", {31'd0, done}, 32'd0);
        chk("idle_after_done", {31'd0, busy}, 32'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        int n;
        logic seen;
        rst = 1'b1;
        start = 1'b0;
        word_rdy = 1'b1;
        chains_in = '0;
        chains_in_vld = '0;
        chains_in_done = '0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dump_en", {30'd0, dump_en}, 32'd0);
        chk("rst_word_out", {24'd0, word_out}, 32'd0);
        chk("rst_word_chain", {27'd0, word_chain}, 32'd0);
        chk("rst_word_last", {31'd0, word_last}, 32'd0);
        chk("rst_word_vld", {31'd0, word_vld}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Full word then done: 0x0D, trailing zero word, empty chain 1.
        expect_word(0, 1'b0, 8'h0D);
        expect_word(0, 1'b1, 8'h00);
        expect_word(1, 1'b1, 8'h00);
        pulse_start();
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        send_bits(0, 8'h0D, 8, 1'b0);
        chk("word_latency", {31'd0, word_vld}, 32'd1);
        send(0, 1'b0, 1'b0, 1'b1);
        send(1, 1'b0, 1'b0, 1'b1);
        wait_done();

        // Partial word with done on the last bit, noise on chain 1, start while busy.
        expect_word(0, 1'b1, 8'h07);
        expect_word(1, 1'b1, 8'h00);
        pulse_start();
        chains_in_vld[1] = 1'b1;
        chains_in[1]     = 1'b1;
        send_bits(0, 8'h03, 2, 1'b0);
        pulse_start();
        send(0, 1'b1, 1'b1, 1'b1);
        chains_in_vld[1] = 1'b0;
        chains_in[1]     = 1'b0;
        send(1, 1'b0, 1'b0, 1'b1);
        wait_done();

        // Backpressure: five words with word_rdy low, dump_en must stop at three queued.
        word_rdy = 1'b0;
        expect_word(0, 1'b0, 8'hA5);
        expect_word(0, 1'b0, 8'h3C);
        expect_word(0, 1'b0, 8'h0F);
        expect_word(0, 1'b0, 8'hF0);
        expect_word(0, 1'b0, 8'h81);
        expect_word(0, 1'b1, 8'h00);
        expect_word(1, 1'b1, 8'h00);
        base = bits_taken;
        pulse_start();
        fork
            begin
                send_bits(0, 8'hA5, 8, 1'b0);
                send_bits(0, 8'h3C, 8, 1'b0);
                send_bits(0, 8'h0F, 8, 1'b0);
                send_bits(0, 8'hF0, 8, 1'b0);
                send_bits(0, 8'h81, 8, 1'b0);
            end
            begin
                repeat (80) @(negedge clk);
                chk("bp_dump_en_low", {30'd0, dump_en}, 32'd0);
                chk("bp_bits_taken", 32'(bits_taken - base), 32'd24);
                chk("bp_word_vld", {31'd0, word_vld}, 32'd1);
                tick();
                word_rdy = 1'b1;
            end
        join
        send(0, 1'b0, 1'b0, 1'b1);
        send(1, 1'b0, 1'b0, 1'b1);
        wait_done();

        // Reset mid-chain with a word still queued: nothing of that run may surface.
        word_rdy = 1'b0;
        pulse_start();
        send_bits(0, 8'h5A, 8, 1'b0);
        send_bits(0, 8'h03, 3, 1'b0);
        base = done_seen;
        rst = 1'b0;
        #1;
        chk("midrst_dump_en", {30'd0, dump_en}, 32'd0);
        chk("midrst_word_vld", {31'd0, word_vld}, 32'd0);
        chk("midrst_word_out", {24'd0, word_out}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        word_rdy = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        repeat (5) tick();
        chk("midrst_no_done", 32'(done_seen - base), 32'd0);
        expect_word(0, 1'b0, 8'h3C);
        expect_word(0, 1'b1, 8'h00);
        expect_word(1, 1'b1, 8'h05);
        pulse_start();
        send_bits(0, 8'h3C, 8, 1'b0);
        send(0, 1'b0, 1'b0, 1'b1);
        send_bits(1, 8'h05, 3, 1'b1);
        wait_done();

`ifdef SHADOW_UNLOAD_TIMEOUT_EN
        // Silent chain 0: watchdog fires after 16 idle enabled cycles and flushes a zero word.
        expect_word(0, 1'b1, 8'h00);
        expect_word(1, 1'b1, 8'h00);
        pulse_start();
        seen = 1'b0;
        n = 0;
        while (!seen && n < 10) begin
            @(negedge clk);
            seen = dump_en[0];
            n++;
        end
        n = 0;
        while (!err && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycle", 32'(n), 32'd16);
        tick();
        send(1, 1'b0, 1'b0, 1'b1);
        wait_done();
        chk("err_sticky", {31'd0, err}, 32'd1);
`else
        seen = 1'b0;
        n = 0;
        chk("err_tied_low", {31'd0, err}, 32'd0);
`endif

        repeat (5) tick();
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
`ifdef SHADOW_UNLOAD_TIMEOUT_EN
        chk("done_count", 32'(done_seen), 32'd5);
`else
        chk("done_count", 32'(done_seen), 32'd4);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shadow_unload.md
SHADOW_UNLOAD -- requirements
Module: shadow_unload

Interface
REQ-001 SHALL have parameter CHAINS, default 4: number of serial shadow chains drained, range 1..32.
REQ-002 SHALL have parameter WORD_W, default 32: deserialized word width, range 8..64.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: output word FIFO depth, a power of two, at least 2.
REQ-004 SHALL have parameter TIMEOUT, default 1024: watchdog limit in cycles, used only with the configuration macro.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: single-cycle pulse that begins an unload of all chains.
REQ-008 SHALL have port dump_en, output, CHAINS bits: one-hot dump enable to the capture block's chains.
REQ-009 SHALL have ports chains_in, chains_in_vld and chains_in_done, each input, CHAINS bits: serial bit, bit-valid and end-of-chain per chain.
REQ-010 SHALL have port word_out, output, WORD_W bits: deserialized word at the FIFO head.
REQ-011 SHALL have port word_chain, output, 5 bits: source chain index of word_out.
REQ-012 SHALL have port word_last, output, 1 bit: word_out is the final word of its chain.
REQ-013 SHALL have ports word_vld (output) and word_rdy (input), each 1 bit: the output handshake.
REQ-014 SHALL have ports busy (output, 1 bit) and done (output, 1 bit, single-cycle pulse).
REQ-015 SHALL have port err, output, 1 bit: sticky timeout flag.

Function
REQ-016 SHALL use FSM states IDLE, DUMP, FLUSH and FIN.
REQ-017 SHALL move from IDLE to DUMP on start, with chain index k=0; start SHALL be ignored outside IDLE.
REQ-018 SHALL, in DUMP, drive dump_en[k]=1 only when the FIFO has at least 2 free entries; otherwise dump_en SHALL be 0 (backpressure).
REQ-019 SHALL write chains_in[k] into bit position bitcnt of the shift word each cycle that chains_in_vld[k]=1 and dump_en[k]=1; bitcnt SHALL then increment; the first bit received lands in bit 0.
REQ-020 SHALL push the word into the FIFO with word_last=0 and clear bitcnt and the word when bitcnt reaches WORD_W-1 and a bit is taken.
REQ-021 SHALL ignore bits with vld set on chains other than k, and bits received while dump_en[k]=0.
REQ-022 SHALL, on chains_in_done[k]=1 (the same-cycle bit is taken first), enter FLUSH.
REQ-023 SHALL, in FLUSH, push the word held in the shift register with unwritten bits zero and word_last=1; when bitcnt=0 with no bit pending, it SHALL push an all-zero word with word_last=1.
REQ-024 SHALL, after FLUSH, increment k and return to DUMP, or go to FIN when k=CHAINS-1.
REQ-025 SHALL, in FIN, pulse done for 1 cycle and return to IDLE.
REQ-026 SHALL assert busy in every state except IDLE.
REQ-027 SHALL make the FIFO first-word-fall-through: word_vld=1 while the FIFO is non-empty; an entry SHALL pop on word_vld and word_rdy.
REQ-028 SHALL support a push and a pop in the same cycle, including when the FIFO is full.
REQ-029 SHALL never overflow the FIFO (guaranteed by REQ-018); an underflow pop is impossible because a pop requires word_vld.
REQ-030 SHALL have a latency from the last bit of a word to word_vld of 1 cycle when the FIFO was empty.

Reset
REQ-031 SHALL, while rst=0, immediately set the FSM to IDLE and k, bitcnt, the word, and the FIFO pointers to 0.
REQ-032 SHALL hold these outputs at 0 during reset: dump_en, word_out, word_chain, word_last, word_vld, busy, done, err.
REQ-033 SHALL discard all in-flight data on reset mid-unload; no done pulse SHALL follow.

Configuration
REQ-034 SHALL, with SHADOW_UNLOAD_TIMEOUT_EN defined, count the consecutive DUMP cycles in which dump_en[k]=1 with neither vld[k] nor done[k].
REQ-035 SHALL, with SHADOW_UNLOAD_TIMEOUT_EN defined, set err (sticky until reset) and force FLUSH for chain k when that count reaches TIMEOUT.
REQ-036 SHALL, without SHADOW_UNLOAD_TIMEOUT_EN, wait indefinitely in DUMP and tie err to 0; no counter SHALL exist.

Verification
REQ-037 SHALL cover: CHAINS=1, WORD_W=8, 8 bits 1,0,1,1,0,0,0,0 then done -> words 0x0D (last=0), then 0x00 (last=1), then done pulse.
REQ-038 SHALL cover: CHAINS=2, chain0 sends 3 bits 1,1,1 plus done, chain1 sends 0 bits plus done -> 0x07 (chain 0, last=1), then 0x00 (chain 1, last=1).
REQ-039 SHALL cover: word_rdy=0, FIFO_DEPTH=4, 40 bits streamed -> dump_en drops with 3 entries queued; no data lost after word_rdy=1.
REQ-040 SHALL cover: rst=0 asserted mid-chain -> outputs 0 immediately; the next start yields only new-run words.
REQ-041 SHALL cover: with the macro defined, TIMEOUT=16 and a silent chain -> err=1 at cycle 16, a zero word with last=1, and progress to the next chain.
REQ-042 SHALL cover: start pulsed while busy -> ignored and the word sequence unchanged.
